// File: rtl/policy_gen_seq.sv
// Sequential Q-table policy generator: picks the largest legal signed Q, one action scanned per clock.
// Latency N_ACT+1 clocks from capture to done pulse; start is ignored while busy (no queueing).
// Optional epsilon-greedy exploration is compiled in with POLICY_EPSILON_EN.
module policy_gen_seq #(
    parameter int N_ACT = 9,
    parameter int Q_W   = 18,
    parameter int IDX_W = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [N_ACT*Q_W-1:0] q_flat,
    input  logic [N_ACT-1:0]     legal,
`ifdef POLICY_EPSILON_EN
    input  logic [7:0]           epsilon,
    output logic                 explored,
`endif
    output logic                 busy,
    output logic                 done,
    output logic [IDX_W-1:0]     next_action,
    output logic [Q_W-1:0]       max_q,
    output logic                 no_legal
);
    typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DONE} state_t;

    localparam logic [IDX_W-1:0]     LAST  = IDX_W'(N_ACT - 1);
    localparam logic signed [Q_W-1:0] Q_MIN = {1'b1, {(Q_W-1){1'b0}}};

    state_t                state_q, state_d;
    logic signed [Q_W-1:0] q_cap_q [N_ACT];
    logic signed [Q_W-1:0] q_cap_d [N_ACT];
    logic [N_ACT-1:0]      legal_q, legal_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic                  best_vld_q, best_vld_d;
    logic signed [Q_W-1:0] best_q_q, best_q_d;
    logic [IDX_W-1:0]      best_idx_q, best_idx_d;
    logic                  done_q, done_d;
    logic [IDX_W-1:0]      next_action_q, next_action_d;
    logic [Q_W-1:0]        max_q_q, max_q_d;
    logic                  no_legal_q, no_legal_d;
    logic signed [Q_W-1:0] cur_q;
    logic                  cur_legal, take, scan_last;
`ifdef POLICY_EPSILON_EN
    logic [15:0]           lfsr_q, lfsr_d;
    logic [IDX_W-1:0]      rot_q, rot_d, cnt_q, cnt_d;
    logic                  explore_q, explore_d, explored_q, explored_d;
`endif

    always_comb begin
        state_d       = state_q;
        q_cap_d       = q_cap_q;
        legal_d       = legal_q;
        idx_d         = idx_q;
        best_vld_d    = best_vld_q;
        best_q_d      = best_q_q;
        best_idx_d    = best_idx_q;
        done_d        = 1'b0;
        next_action_d = next_action_q;
        max_q_d       = max_q_q;
        no_legal_d    = no_legal_q;
        cur_q         = q_cap_q[idx_q];
        cur_legal     = legal_q[idx_q];
`ifdef POLICY_EPSILON_EN
        lfsr_d     = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
        rot_d      = (rot_q == LAST) ? '0 : rot_q + IDX_W'(1);
        cnt_d      = cnt_q;
        explore_d  = explore_q;
        explored_d = explored_q;
        // The scan position may start mid-table, so a separate count ends the pass.
        scan_last  = (cnt_q == LAST);
        take       = cur_legal && (!best_vld_q || (!explore_q && (cur_q > best_q_q)));
`else
        scan_last  = (idx_q == LAST);
        take       = cur_legal && (!best_vld_q || (cur_q > best_q_q));
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    for (int i = 0; i < N_ACT; i++) q_cap_d[i] = q_flat[i*Q_W +: Q_W];
                    legal_d    = legal;
                    best_vld_d = 1'b0;
                    best_q_d   = Q_MIN;
                    best_idx_d = '0;
                    idx_d      = '0;
`ifdef POLICY_EPSILON_EN
                    explore_d  = (lfsr_q[7:0] < epsilon);
                    cnt_d      = '0;
                    if (explore_d) idx_d = rot_q;
`endif
                    state_d    = S_SCAN;
                end
            end
            S_SCAN: begin
                // Strict greater-than keeps the lowest index on ties.
                if (take) begin
                    best_vld_d = 1'b1;
                    best_q_d   = cur_q;
                    best_idx_d = idx_q;
                end
                idx_d = (idx_q == LAST) ? '0 : idx_q + IDX_W'(1);
`ifdef POLICY_EPSILON_EN
                cnt_d = cnt_q + IDX_W'(1);
`endif
                if (scan_last) state_d = S_DONE;
            end
            S_DONE: begin
                done_d        = 1'b1;
                next_action_d = best_idx_q;
                max_q_d       = best_q_q;
                no_legal_d    = !best_vld_q;
`ifdef POLICY_EPSILON_EN
                explored_d    = explore_q && best_vld_q;
`endif
                state_d       = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            for (int i = 0; i < N_ACT; i++) q_cap_q[i] <= '0;
            legal_q       <= '0;
            idx_q         <= '0;
            best_vld_q    <= 1'b0;
            best_q_q      <= '0;
            best_idx_q    <= '0;
            done_q        <= 1'b0;
            next_action_q <= '0;
            max_q_q       <= '0;
            no_legal_q    <= 1'b0;
`ifdef POLICY_EPSILON_EN
            lfsr_q        <= 16'hACE1;
            rot_q         <= '0;
            cnt_q         <= '0;
            explore_q     <= 1'b0;
            explored_q    <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            q_cap_q       <= q_cap_d;
            legal_q       <= legal_d;
            idx_q         <= idx_d;
            best_vld_q    <= best_vld_d;
            best_q_q      <= best_q_d;
            best_idx_q    <= best_idx_d;
            done_q        <= done_d;
            next_action_q <= next_action_d;
            max_q_q       <= max_q_d;
            no_legal_q    <= no_legal_d;
`ifdef POLICY_EPSILON_EN
            lfsr_q        <= lfsr_d;
            rot_q         <= rot_d;
            cnt_q         <= cnt_d;
            explore_q     <= explore_d;
            explored_q    <= explored_d;
`endif
        end
    end

    assign busy        = (state_q != S_IDLE);
    assign done        = done_q;
    assign next_action = next_action_q;
    assign max_q       = max_q_q;
    assign no_legal    = no_legal_q;
`ifdef POLICY_EPSILON_EN
    assign explored    = explored_q;
`endif

endmodule

// File: tb/tb_policy_gen_seq.sv
// Directed bench for policy_gen_seq; greedy scenarios by default, epsilon scenarios with POLICY_EPSILON_EN.
`timescale 1ns/1ps
module tb_policy_gen_seq;
`ifdef POLICY_EPSILON_EN
    localparam int N  = 4;
    localparam int QW = 8;
    localparam int IW = 2;
`else
    localparam int N  = 9;
    localparam int QW = 18;
    localparam int IW = 4;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [N*QW-1:0] q_flat = '0;
    logic [N-1:0]  legal = '0;
    logic          busy, done, no_legal;
    logic [IW-1:0] next_action;
    logic [QW-1:0] max_q;
    int            tests = 0;
    int            fails = 0;
`ifdef POLICY_EPSILON_EN
    logic [7:0]    epsilon = 8'd0;
    logic          explored;
    logic [15:0]   m_lfsr;
    int            m_rot;
    logic [15:0]   cap_lfsr;
    int            cap_rot;
`endif

    always #5 clk = ~clk;

    policy_gen_seq #(.N_ACT(N), .Q_W(QW), .IDX_W(IW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .q_flat(q_flat), .legal(legal),
`ifdef POLICY_EPSILON_EN
        .epsilon(epsilon), .explored(explored),
`endif
        .busy(busy), .done(done), .next_action(next_action), .max_q(max_q), .no_legal(no_legal)
    );

`ifdef POLICY_EPSILON_EN
    // Reference LFSR and rotation counter, both free-running from reset release.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_lfsr <= 16'hACE1;
            m_rot  <= 0;
        end else begin
            m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
            m_rot  <= (m_rot + 1) % N;
        end
    end
`endif

    function automatic logic [N*QW-1:0] pack(input int v[N]);
        logic [N*QW-1:0] r;
        r = '0;
        for (int i = 0; i < N; i++) r[i*QW +: QW] = v[i][QW-1:0];
        return r;
    endfunction

    // Called at a negedge; returns at the negedge where done is seen (lat = edges after capture).
    task automatic do_op(input logic [N*QW-1:0] qf, input logic [N-1:0] lg, output int lat);
        q_flat = qf;
        legal  = lg;
        start  = 1'b1;
`ifdef POLICY_EPSILON_EN
        cap_lfsr = m_lfsr;
        cap_rot  = m_rot;
`endif
        @(posedge clk);
        @(negedge clk);
        start  = 1'b0;
        q_flat = ~qf;
        legal  = ~lg;
        lat = -1;
        for (int i = 1; i <= 4*N && lat < 0; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (done) lat = i;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b0;
        repeat (3) @(negedge clk);
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b want 0", busy); end
        tests++; if (done !== 1'b0) begin fails++; $display("FAIL reset_done: got %b want 0", done); end
        tests++; if (next_action !== '0) begin fails++; $display("FAIL reset_next_action: got %0d want 0", next_action); end
        tests++; if (max_q !== '0) begin fails++; $display("FAIL reset_max_q: got %h want 0", max_q); end
        tests++; if (no_legal !== 1'b0) begin fails++; $display("FAIL reset_no_legal: got %b want 0", no_legal); end
`ifdef POLICY_EPSILON_EN
        tests++; if (explored !== 1'b0) begin fails++; $display("FAIL reset_explored: got %b want 0", explored); end
`endif
        rst_n = 1'b1;
        @(negedge clk);
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL idle_busy: got %b want 0", busy); end
    endtask

`ifdef POLICY_EPSILON_EN
    logic [N-1:0] masks [4] = '{4'hF, 4'hB, 4'h2, 4'h8};
    int           g_idx [4] = '{2, 0, 1, 3};
    int           g_q   [4] = '{30, 10, -20, 5};

    task automatic test_eps_greedy();
        int v[N];
        int lat;
        int k;
        v = '{10, -20, 30, 5};
        epsilon = 8'd0;
        for (int r = 0; r < 100; r++) begin
            k = r % 4;
            do_op(pack(v), masks[k], lat);
            tests++; if (lat !== N + 1) begin fails++; $display("FAIL eps0_latency run %0d: got %0d want %0d", r, lat, N + 1); end
            tests++; if (explored !== 1'b0) begin fails++; $display("FAIL eps0_explored run %0d: got %b want 0", r, explored); end
            tests++; if (next_action !== IW'(g_idx[k])) begin fails++; $display("FAIL eps0_next_action run %0d: got %0d want %0d", r, next_action, g_idx[k]); end
            tests++; if (max_q !== QW'(g_q[k])) begin fails++; $display("FAIL eps0_max_q run %0d: got %h want %h", r, max_q, QW'(g_q[k])); end
        end
    endtask

    task automatic test_eps_explore();
        int v[N];
        int lat, k, eidx, c;
        logic eexp;
        v = '{10, -20, 30, 5};
        epsilon = 8'd255;
        for (int r = 0; r < 100; r++) begin
            k = r % 4;
            do_op(pack(v), masks[k], lat);
            eexp = (cap_lfsr[7:0] != 8'hFF);
            eidx = g_idx[k];
            if (eexp) begin
                eidx = -1;
                for (int j = 0; j < N; j++) begin
                    c = (cap_rot + j) % N;
                    if (eidx < 0 && masks[k][c]) eidx = c;
                end
            end
            tests++; if (explored !== eexp) begin fails++; $display("FAIL eps255_explored run %0d: got %b want %b", r, explored, eexp); end
            tests++; if (next_action !== IW'(eidx)) begin fails++; $display("FAIL eps255_next_action run %0d: got %0d want %0d", r, next_action, eidx); end
            tests++; if (max_q !== QW'(v[eidx])) begin fails++; $display("FAIL eps255_max_q run %0d: got %h want %h", r, max_q, QW'(v[eidx])); end
            tests++; if (masks[k][next_action] !== 1'b1) begin fails++; $display("FAIL eps255_legal_pick run %0d: got index %0d mask %h", r, next_action, masks[k]); end
        end
        do_op(pack(v), 4'h0, lat);
        tests++; if (no_legal !== 1'b1) begin fails++; $display("FAIL eps255_no_legal: got %b want 1", no_legal); end
        tests++; if (explored !== 1'b0) begin fails++; $display("FAIL eps255_none_explored: got %b want 0", explored); end
        tests++; if (max_q !== 8'h80) begin fails++; $display("FAIL eps255_none_max_q: got %h want 80", max_q); end
    endtask
`else
    task automatic test_greedy();
        int v[N];
        int lat;
        v = '{5, -3, 12, 7, 12, 0, 1, 2, -8};
        do_op(pack(v), 9'h1FF, lat);
        tests++; if (lat !== 10) begin fails++; $display("FAIL greedy_latency: got %0d want 10", lat); end
        tests++; if (next_action !== 4'd2) begin fails++; $display("FAIL greedy_tie_idx: got %0d want 2", next_action); end
        tests++; if (max_q !== 18'd12) begin fails++; $display("FAIL greedy_tie_q: got %h want 0000c", max_q); end
        tests++; if (no_legal !== 1'b0) begin fails++; $display("FAIL greedy_no_legal: got %b want 0", no_legal); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL greedy_busy_at_done: got %b want 0", busy); end
        do_op(pack(v), 9'h1FB, lat);
        tests++; if (next_action !== 4'd4) begin fails++; $display("FAIL mask2_idx: got %0d want 4", next_action); end
        tests++; if (max_q !== 18'd12) begin fails++; $display("FAIL mask2_q: got %h want 0000c", max_q); end
        do_op(pack(v), 9'h1EB, lat);
        tests++; if (next_action !== 4'd3) begin fails++; $display("FAIL mask24_idx: got %0d want 3", next_action); end
        tests++; if (max_q !== 18'd7) begin fails++; $display("FAIL mask24_q: got %h want 00007", max_q); end
    endtask

    task automatic test_signed();
        int v[N];
        int lat;
        v = '{-1, -5, -2, -7, -9, -3, -4, -6, -8};
        do_op(pack(v), 9'h1FE, lat);
        tests++; if (next_action !== 4'd2) begin fails++; $display("FAIL neg_idx: got %0d want 2", next_action); end
        tests++; if (max_q !== 18'h3FFFE) begin fails++; $display("FAIL neg_q: got %h want 3fffe", max_q); end
        v = '{-1, -5, 3, -7, -9, -3, -4, -6, -8};
        do_op(pack(v), 9'h1FF, lat);
        tests++; if (next_action !== 4'd2) begin fails++; $display("FAIL mixed_sign_idx: got %0d want 2", next_action); end
        tests++; if (max_q !== 18'd3) begin fails++; $display("FAIL mixed_sign_q: got %h want 00003", max_q); end
    endtask

    task automatic test_no_legal();
        int v[N];
        int lat;
        v = '{5, -3, 12, 7, 12, 0, 1, 2, -8};
        do_op(pack(v), 9'h000, lat);
        tests++; if (lat !== 10) begin fails++; $display("FAIL none_latency: got %0d want 10", lat); end
        tests++; if (no_legal !== 1'b1) begin fails++; $display("FAIL none_flag: got %b want 1", no_legal); end
        tests++; if (next_action !== 4'd0) begin fails++; $display("FAIL none_idx: got %0d want 0", next_action); end
        tests++; if (max_q !== 18'h20000) begin fails++; $display("FAIL none_q: got %h want 20000", max_q); end
        do_op(pack(v), 9'h100, lat);
        tests++; if (next_action !== 4'd8) begin fails++; $display("FAIL last_only_idx: got %0d want 8", next_action); end
        tests++; if (max_q !== 18'h3FFF8) begin fails++; $display("FAIL last_only_q: got %h want 3fff8", max_q); end
        tests++; if (no_legal !== 1'b0) begin fails++; $display("FAIL last_only_flag: got %b want 0", no_legal); end
        do_op(pack(v), 9'h1FF, lat);
        tests++; if (no_legal !== 1'b0) begin fails++; $display("FAIL recover_flag: got %b want 0", no_legal); end
        tests++; if (next_action !== 4'd2) begin fails++; $display("FAIL recover_idx: got %0d want 2", next_action); end
    endtask

    task automatic test_hold();
        repeat (5) @(negedge clk);
        tests++; if (done !== 1'b0) begin fails++; $display("FAIL hold_done: got %b want 0", done); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL hold_busy: got %b want 0", busy); end
        tests++; if (next_action !== 4'd2) begin fails++; $display("FAIL hold_idx: got %0d want 2", next_action); end
        tests++; if (max_q !== 18'd12) begin fails++; $display("FAIL hold_q: got %h want 0000c", max_q); end
    endtask

    task automatic test_busy_and_reset();
        int v[N];
        int lat;
        bit saw_done;
        v = '{5, -3, 12, 7, 12, 0, 1, 2, -8};
        q_flat = pack(v);
        legal  = 9'h1FF;
        start  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        q_flat = '0;
        legal  = '0;
        lat = -1;
        for (int i = 1; i <= 4*N && lat < 0; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (done) lat = i;
        end
        start = 1'b0;
        tests++; if (lat !== 10) begin fails++; $display("FAIL held_start_latency: got %0d want 10", lat); end
        tests++; if (next_action !== 4'd2) begin fails++; $display("FAIL held_start_idx: got %0d want 2", next_action); end
        @(negedge clk);
        q_flat = pack(v);
        legal  = 9'h1EB;
        start  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        saw_done = 1'b0;
        repeat (4) begin
            @(posedge clk);
            @(negedge clk);
            if (done) saw_done = 1'b1;
        end
        rst_n = 1'b0;
        #1;
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL abort_busy: got %b want 0", busy); end
        tests++; if (next_action !== 4'd0) begin fails++; $display("FAIL abort_idx: got %0d want 0", next_action); end
        tests++; if (max_q !== 18'd0) begin fails++; $display("FAIL abort_q: got %h want 0", max_q); end
        tests++; if (no_legal !== 1'b0) begin fails++; $display("FAIL abort_flag: got %b want 0", no_legal); end
        @(negedge clk);
        rst_n = 1'b1;
        start = 1'b0;
        repeat (2*N) begin
            @(negedge clk);
            if (done) saw_done = 1'b1;
        end
        tests++; if (saw_done !== 1'b0) begin fails++; $display("FAIL abort_no_done: got %b want 0", saw_done); end
        do_op(pack(v), 9'h1EB, lat);
        tests++; if (lat !== 10) begin fails++; $display("FAIL post_reset_latency: got %0d want 10", lat); end
        tests++; if (next_action !== 4'd3) begin fails++; $display("FAIL post_reset_idx: got %0d want 3", next_action); end
        tests++; if (max_q !== 18'd7) begin fails++; $display("FAIL post_reset_q: got %h want 00007", max_q); end
    endtask

    task automatic test_back_to_back();
        int v[N];
        int v2[N];
        int lat;
        v  = '{5, -3, 12, 7, 12, 0, 1, 2, -8};
        v2 = '{0, 1, 2, 3, 4, 5, 6, 7, 8};
        do_op(pack(v), 9'h1FF, lat);
        q_flat = pack(v2);
        legal  = 9'h1FF;
        start  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        tests++; if (done !== 1'b0) begin fails++; $display("FAIL b2b_done_pulse: got %b want 0", done); end
        tests++; if (busy !== 1'b1) begin fails++; $display("FAIL b2b_accepted: got %b want 1", busy); end
        lat = -1;
        for (int i = 1; i <= 4*N && lat < 0; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (done) lat = i;
        end
        tests++; if (lat !== 10) begin fails++; $display("FAIL b2b_latency: got %0d want 10", lat); end
        tests++; if (next_action !== 4'd8) begin fails++; $display("FAIL b2b_idx: got %0d want 8", next_action); end
        tests++; if (max_q !== 18'd8) begin fails++; $display("FAIL b2b_q: got %h want 00008", max_q); end
    endtask
`endif

    initial begin
        test_reset();
`ifdef POLICY_EPSILON_EN
        test_eps_greedy();
        test_eps_explore();
`else
        test_greedy();
        test_signed();
        test_no_legal();
        test_hold();
        test_busy_and_reset();
        test_back_to_back();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/policy_gen_seq.md
Name: policy_gen_seq

Overview:
Parametrised, sequential successor to the combinational Q-table policy generator. On a start pulse it captures N_ACT signed Q values and a legality mask. It then scans one entry per clock and returns the index of the largest legal Q value, so occupied board cells are never chosen. It sits between the Q-table RAM readout and the agent move/update controller, and replaces the flat 9-way comparator with a registered, width-generic datapath.

Parameters:
N_ACT, 9, number of actions (board cells); legal range 2..16
Q_W, 18, Q value width, signed two's complement
IDX_W, 4, action index width; must satisfy 2**IDX_W >= N_ACT

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  request; sampled only in IDLE
q_flat  in  N_ACT*Q_W  packed Q values; action i occupies bits [i*Q_W +: Q_W]
legal  in  N_ACT  1 = action i legal (cell empty)
busy  out  1  high in SCAN and DONE states
done  out  1  one-cycle pulse; results valid from this cycle on
next_action  out  IDX_W  chosen action index
max_q  out  Q_W  Q value of the chosen action
no_legal  out  1  set when legal was all zero at capture
epsilon  in  8  exploration threshold (present only with POLICY_EPSILON_EN)
explored  out  1  chosen action came from exploration (present only with POLICY_EPSILON_EN)

Behaviour:
- One clock. Reset is asynchronous and active-low.
- Reset values: busy=0, done=0, next_action=0, max_q=0, no_legal=0, explored=0. The FSM resets to IDLE.
- FSM states: IDLE, SCAN, DONE.
- IDLE, start=1:
  - register q_flat and legal into internal copies
  - clear the best-valid flag
  - idx <= 0
  - go to SCAN
- Input stability: q_flat and legal may change freely after the capture cycle.
- SCAN, one entry per cycle at idx:
  - If entry is legal and (no best yet, or Q > best_q, signed compare), then best_q <= Q and best_idx <= idx.
  - The compare is strict greater-than, so on ties the lowest index wins.
  - When idx == N_ACT-1, go to DONE; otherwise idx++.
- DONE, held one cycle:
  - done=1
  - next_action and max_q load from best_idx and best_q
  - no_legal = !best-valid
  - then return to IDLE
- Latency: start sampled at edge k; done high in the cycle after edge k+N_ACT+1 (N_ACT+1 clocks after the capture edge).
- Output hold: results hold until the next DONE. Only done is a pulse.
- All-illegal mask: no_legal=1, next_action=0, max_q = most negative value (1 followed by Q_W-1 zeros).
- start while busy: ignored, not queued.
- start asserted the same cycle the FSM enters IDLE from DONE: accepted (back-to-back operations allowed, throughput N_ACT+2 cycles).
- Reset asserted mid-SCAN: immediate abort to reset values. No done pulse is produced.
- No arithmetic beyond the compare. Q values are never truncated; max_q is full Q_W width.

Optional Feature:
Macro POLICY_EPSILON_EN.
- Defined:
  - A 16-bit Fibonacci LFSR (x^16+x^14+x^13+x^11+1, reset seed 16'hACE1) advances every clock.
  - A free-running mod-N_ACT counter rot advances every clock.
  - At capture, explore flag <= (lfsr[7:0] < epsilon).
  - If explore: SCAN starts at idx=rot and wraps modulo N_ACT, still N_ACT cycles. The first legal entry encountered is chosen and max_q reports its Q. Then explored=1.
  - Otherwise behaviour is greedy as above and explored=0.
  - epsilon=0 is always greedy. epsilon=255 explores except when lfsr[7:0]=255.
  - An all-illegal mask yields no_legal=1 and explored=0 regardless of explore flag.
- Undefined: epsilon and explored ports are absent, and there is no LFSR or counter. Behaviour is purely greedy.

Test Plan:
- Q = {5,-3,12,7,12,0,1,2,-8} (index 0..8), legal=9'h1FF -> done after N_ACT+1 clocks, next_action=2, max_q=12 (tie with index 4 resolved low).
- Same Q, legal bit 2 cleared -> next_action=4, max_q=12; with bits 2 and 4 cleared -> next_action=3, max_q=7.
- All Q negative {-1,-5,-2,...}, legal=9'h1FE -> next_action=2 if Q[2]=-2 is the largest legal value; verifies signed compare, no unsigned wrap.
- legal=0 -> no_legal=1, next_action=0, max_q=18'h20000. Then start with legal=9'h1FF -> no_legal returns to 0.
- Pulse start every cycle, and assert rst_n=0 at SCAN idx=4 -> extra starts ignored while busy; reset clears all outputs, no done pulse; next start completes normally.
- POLICY_EPSILON_EN, N_ACT=4, Q_W=8: epsilon=0 over 100 runs -> explored always 0, greedy index. epsilon=255 over 100 runs -> explored=1 except when lfsr[7:0]=255, and every chosen index is legal.
